tb_dina_map: RTL

Write-side lane mapper for the temp buffer (TB) port A. It takes result rows streamed out of the RSA systolic array and turns them into TB port-A write transactions (data, address, per-lane write enables). It supports direct, lane-reversed, half-word (NEW) and 2×2 transpose placements. It complements the port-B read mapper that feeds TB data into the array's B inputs.

---
 rtl/ekf_tb_pkg.sv | 51 +++++
 rtl/tb_dina_map.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ekf_tb_pkg.sv
// Shared definitions for the temp-buffer port mappers: mode codes, widths
// and lane placement helpers used by both the write and read side.
package ekf_tb_pkg;

  localparam int X              = 4;
  localparam int L              = 4;
  localparam int RSA_DW         = 32;
  localparam int TB_AW          = 10;
  localparam int TB_DINA_SEL_DW = 5;
  localparam int LEN_DW         = 6;

  localparam logic [2:0] TBa_IDLE      = 3'b000;
  localparam logic [2:0] TBa_DIRECT    = 3'b001;
  localparam logic [2:0] TBa_TRANSPOSE = 3'b110;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b10;
  localparam logic [1:0] DIR_NEW  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dina_state_e;

  function automatic logic [X*RSA_DW-1:0] lane_rev(input logic [X*RSA_DW-1:0] v);
    logic [X*RSA_DW-1:0] r;
    for (int i = 0; i < X; i++) begin
      r[i*RSA_DW +: RSA_DW] = v[(X-1-i)*RSA_DW +: RSA_DW];
    end
    return r;
  endfunction

  // Place a two-element pair in the low half (lanes 1,0) or high half (lanes 3,2).
  function automatic logic [L*RSA_DW-1:0] half_place(input logic [RSA_DW-1:0] hi,
                                                     input logic [RSA_DW-1:0] lo,
                                                     input logic              lo_half);
    logic [L*RSA_DW-1:0] r;
    r = '0;
    if (lo_half) r[2*RSA_DW-1:0] = {hi, lo};
    else         r[L*RSA_DW-1 -: 2*RSA_DW] = {hi, lo};
    return r;
  endfunction

  function automatic logic [L-1:0] half_wea(input logic lo_half);
    return lo_half ? 4'b0011 : 4'b1100;
  endfunction

endpackage

// File: rtl/tb_dina_map.sv
// TB port-A write mapper: turns streamed RSA result rows into TB writes in
// direct, lane-reversed, half-word and 2x2 transpose placements.
//
// state    | meaning
// IDLE     | waiting for start; C_valid beats are dropped
// RUN      | accepting beats (direct writes, or transpose buffering)
// DRAIN    | transpose second write pending
// DONE     | done pulse cycle; final write (if any) is on the outputs
module tb_dina_map
  import ekf_tb_pkg::*;
(
  input  logic                      clk,
  input  logic                      sys_rst_n,
  input  logic                      start,
  input  logic [TB_DINA_SEL_DW-1:0] TB_dina_sel,
  input  logic                      l_k_0,
  input  logic [TB_AW-1:0]          base_addr,
  input  logic [LEN_DW-1:0]         len,
  input  logic [X*RSA_DW-1:0]       C_dout,
  input  logic                      C_valid,
  output logic [L*RSA_DW-1:0]       TB_dina,
  output logic [TB_AW-1:0]          TB_addra,
  output logic                      TB_ena,
  output logic [L-1:0]              TB_wea,
  output logic                      busy,
  output logic                      done,
  output logic                      drop
);

  dina_state_e          state_q, state_d;
  logic [2:0]           grp_q, grp_d;
  logic [1:0]           dir_q, dir_d;
  logic                 lk_q, lk_d;
  logic [TB_AW-1:0]     addr_q, addr_d;
  logic [LEN_DW-1:0]    len_q, len_d;
  logic [LEN_DW-1:0]    cnt_q, cnt_d;
  logic [RSA_DW-1:0]    c00_q, c00_d, c01_q, c01_d, c10_q, c10_d, c11_q, c11_d;
  logic [L*RSA_DW-1:0]  dina_q, dina_d;
  logic [TB_AW-1:0]     addra_q, addra_d;
  logic                 ena_q, ena_d;
  logic [L-1:0]         wea_q, wea_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 drop_q, drop_d;

  logic [2:0]           start_grp;
  logic [1:0]           start_dir;
  logic [RSA_DW-1:0]    c_lane0, c_lane1;

  assign start_grp = TB_dina_sel[4:2];
  assign start_dir = TB_dina_sel[1:0];
  assign c_lane0   = C_dout[RSA_DW-1:0];
  assign c_lane1   = C_dout[2*RSA_DW-1:RSA_DW];

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    dir_d   = dir_q;
    lk_d    = lk_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    c00_d   = c00_q;
    c01_d   = c01_q;
    c10_d   = c10_q;
    c11_d   = c11_q;
    dina_d  = '0;
    addra_d = '0;
    ena_d   = 1'b0;
    wea_d   = '0;
    drop_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        drop_d = C_valid;
        if (start) begin
          grp_d  = start_grp;
          dir_d  = start_dir;
          lk_d   = l_k_0;
          addr_d = base_addr;
          len_d  = len;
          cnt_d  = '0;
          if (start_grp == TBa_TRANSPOSE ||
              (start_grp == TBa_DIRECT && start_dir != DIR_IDLE && len != '0))
            state_d = ST_RUN;
          else
            state_d = ST_DONE;
        end
      end

      ST_RUN: begin
        if (C_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (grp_q == TBa_TRANSPOSE) begin
            if (cnt_q == '0) begin
              c00_d = c_lane0;
              c01_d = c_lane1;
            end else begin
              // Second beat completes the 2x2 block; first column goes out now.
              c10_d   = c_lane0;
              c11_d   = c_lane1;
              ena_d   = 1'b1;
              addra_d = addr_q;
              addr_d  = addr_q + 1'b1;
              dina_d  = half_place(c_lane0, c00_q, lk_q);
              wea_d   = half_wea(lk_q);
              state_d = ST_DRAIN;
            end
          end else begin
            ena_d   = 1'b1;
            addra_d = addr_q;
            addr_d  = addr_q + 1'b1;
            case (dir_q)
              DIR_POS: begin
                dina_d = C_dout;
                wea_d  = '1;
              end
              DIR_NEG: begin
                dina_d = lane_rev(C_dout);
                wea_d  = '1;
              end
              default: begin
                dina_d = half_place(c_lane1, c_lane0, lk_q);
                wea_d  = half_wea(lk_q);
              end
            endcase
            if (cnt_q == len_q - 1'b1) state_d = ST_DONE;
          end
        end
      end

      ST_DRAIN: begin
        drop_d  = C_valid;
        ena_d   = 1'b1;
        addra_d = addr_q;
        dina_d  = half_place(c11_q, c01_q, lk_q);
        wea_d   = half_wea(lk_q);
        state_d = ST_DONE;
      end

      ST_DONE: begin
        drop_d  = C_valid;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      grp_q   <= '0;
      dir_q   <= '0;
      lk_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      c00_q   <= '0;
      c01_q   <= '0;
      c10_q   <= '0;
      c11_q   <= '0;
      dina_q  <= '0;
      addra_q <= '0;
      ena_q   <= 1'b0;
      wea_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      dir_q   <= dir_d;
      lk_q    <= lk_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      c00_q   <= c00_d;
      c01_q   <= c01_d;
      c10_q   <= c10_d;
      c11_q   <= c11_d;
      dina_q  <= dina_d;
      addra_q <= addra_d;
      ena_q   <= ena_d;
      wea_q   <= wea_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign TB_dina  = dina_q;
  assign TB_addra = addra_q;
  assign TB_ena   = ena_q;
  assign TB_wea   = wea_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign drop     = drop_q;

endmodule
